// File: rtl/ioexp_pkg.sv
// Shared constants and FSM states for the SMBus I/O expander bank.
// Register map: INPUT 0x00+p, OUTPUT 0x10+p, POLARITY 0x20+p, CONFIG 0x30+p, MASK 0x40+p.
package ioexp_pkg;

   localparam logic [7:0] OFF_IN      = 8'h00;
   localparam logic [7:0] OFF_OUT     = 8'h10;
   localparam logic [7:0] OFF_POL     = 8'h20;
   localparam logic [7:0] OFF_CFG     = 8'h30;
   localparam logic [7:0] OFF_MSK     = 8'h40;
   localparam logic [7:0] RD_UNMAPPED = 8'hFF;

   typedef enum logic [1:0] {
      ST_ARMING,
      ST_ARMED,
      ST_ASSERT,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/ioexp_port_slice.sv
// One 8-bit expander port: OUTPUT/CONFIG/MASK/POLARITY, snapshot, change detect, pending.
// POLARITY flops exist only when IOEXP_POLARITY_EN is defined.
module ioexp_port_slice
   import ioexp_pkg::*;
#(
   parameter int IDX = 0
) (
   input  logic       iClk,
   input  logic       nrst,
   input  logic       cfg_dflt_i,
   input  logic       wr_en_i,
   input  logic       rd_en_i,
   input  logic [7:0] offset_i,
   input  logic [7:0] wr_data_i,
   input  logic [7:0] pin_i,
   input  logic       arm_i,
   input  logic       trig_i,
   output logic [7:0] out_o,
   output logic [7:0] cfg_o,
   output logic [7:0] msk_o,
   output logic [7:0] pol_o,
   output logic [7:0] snap_o,
   output logic [7:0] drv_o,
   output logic       chg_o,
   output logic       pend_o,
   output logic       pend_d_o
);

   localparam logic [7:0] SEL = 8'(IDX);

   logic [7:0] out_q, cfg_q, msk_q, snap_q;
   logic       pend_q, pend_d;
   logic       wr_out, wr_cfg, wr_msk, rd_clr;

   assign wr_out = wr_en_i & (offset_i == (OFF_OUT + SEL));
   assign wr_cfg = wr_en_i & (offset_i == (OFF_CFG + SEL));
   assign wr_msk = wr_en_i & (offset_i == (OFF_MSK + SEL));
   assign rd_clr = rd_en_i & (offset_i == (OFF_IN + SEL));

   // Host-writable control registers
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         out_q <= 8'hFF;
         cfg_q <= {8{cfg_dflt_i}};
         msk_q <= 8'h00;
      end else begin
         if (wr_out) out_q <= wr_data_i;
         if (wr_cfg) cfg_q <= wr_data_i;
         if (wr_msk) msk_q <= wr_data_i;
      end
   end

`ifdef IOEXP_POLARITY_EN
   logic [7:0] pol_q;
   logic       wr_pol;

   assign wr_pol = wr_en_i & (offset_i == (OFF_POL + SEL));

   // Input inversion register
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) pol_q <= 8'h00;
      else if (wr_pol) pol_q <= wr_data_i;
   end

   assign pol_o = pol_q;
`else
   assign pol_o = 8'h00;
`endif

   assign chg_o = |((pin_i ^ snap_q) & ~msk_q);

   // Trigger latches which ports changed; reading INPUT clears it
   always_comb begin
      pend_d = pend_q;
      if (trig_i) pend_d = chg_o;
      else if (rd_clr) pend_d = 1'b0;
   end

   // Snapshot taken on arming and on the triggering cycle
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         snap_q <= 8'h00;
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         if (arm_i | trig_i) snap_q <= pin_i;
      end
   end

   assign out_o    = out_q;
   assign cfg_o    = cfg_q;
   assign msk_o    = msk_q;
   assign snap_o   = snap_q;
   assign pend_o   = pend_q;
   assign pend_d_o = pend_d;
   assign drv_o    = (cfg_q & pin_i) | (~cfg_q & out_q);

endmodule

// File: rtl/smbus_ioexp_bank.sv
// SMBus-attached bank of 8-bit I/O expander ports with a shared interrupt FSM.
// Optional POLARITY registers are built when IOEXP_POLARITY_EN is defined.
module smbus_ioexp_bank
   import ioexp_pkg::*;
#(
   parameter int NPORTS       = 2,
   parameter int INT_HOLD_CYC = 2250
) (
   input  logic                iClk,
   input  logic                nrst,
   input  logic                iWrEn,
   input  logic                iRdEn,
   input  logic [7:0]          iOffset,
   input  logic [7:0]          iWrData,
   output logic [7:0]          oRdData,
   input  logic [8*NPORTS-1:0] iPins,
   input  logic [NPORTS-1:0]   iCfgDflt,
   input  logic                iIntEn_n,
   output logic                oIntN,
   output logic [8*NPORTS-1:0] oPins
);

   localparam logic [15:0] HOLD_LAST = 16'(INT_HOLD_CYC - 1);

   state_e      state_q;
   logic        int_q;
   logic [15:0] cnt_q;

   logic [7:0]        out_w  [NPORTS];
   logic [7:0]        cfg_w  [NPORTS];
   logic [7:0]        msk_w  [NPORTS];
   logic [7:0]        pol_w  [NPORTS];
   logic [7:0]        snap_w [NPORTS];
   logic [NPORTS-1:0] chg_w, pend_w, pend_d_w;
   logic              arm, trig;

   assign arm  = (state_q == ST_ARMING);
   assign trig = (state_q == ST_ARMED) & (|chg_w);

   for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
      ioexp_port_slice #(.IDX(gp)) u_slice (
         .iClk       (iClk),
         .nrst       (nrst),
         .cfg_dflt_i (iCfgDflt[gp]),
         .wr_en_i    (iWrEn),
         .rd_en_i    (iRdEn),
         .offset_i   (iOffset),
         .wr_data_i  (iWrData),
         .pin_i      (iPins[8*gp +: 8]),
         .arm_i      (arm),
         .trig_i     (trig),
         .out_o      (out_w[gp]),
         .cfg_o      (cfg_w[gp]),
         .msk_o      (msk_w[gp]),
         .pol_o      (pol_w[gp]),
         .snap_o     (snap_w[gp]),
         .drv_o      (oPins[8*gp +: 8]),
         .chg_o      (chg_w[gp]),
         .pend_o     (pend_w[gp]),
         .pend_d_o   (pend_d_w[gp])
      );
   end

   // Interrupt sequencing: arm, wait for change, assert until read, hold off
   always_ff @(posedge iClk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_ARMING;
         int_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            ST_ARMING: state_q <= ST_ARMED;
            ST_ARMED: begin
               if (|chg_w) begin
                  state_q <= ST_ASSERT;
                  int_q   <= 1'b1;
               end
            end
            ST_ASSERT: begin
               if (pend_d_w == '0) begin
                  state_q <= ST_HOLD;
                  int_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) state_q <= ST_ARMING;
               else cnt_q <= cnt_q + 16'd1;
            end
            default: state_q <= ST_ARMING;
         endcase
      end
   end

   assign oIntN = ~(int_q & ~iIntEn_n);

   // Register read mux; INPUT shows the snapshot while the interrupt is low
   always_comb begin
      oRdData = RD_UNMAPPED;
      for (int p = 0; p < NPORTS; p++) begin
         if (iOffset == (OFF_IN + 8'(p)))
            oRdData = (oIntN ? iPins[8*p +: 8] : snap_w[p]) ^ pol_w[p];
         if (iOffset == (OFF_OUT + 8'(p))) oRdData = out_w[p];
         if (iOffset == (OFF_POL + 8'(p))) oRdData = pol_w[p];
         if (iOffset == (OFF_CFG + 8'(p))) oRdData = cfg_w[p];
         if (iOffset == (OFF_MSK + 8'(p))) oRdData = msk_w[p];
      end
   end

   logic unused_ok;
   assign unused_ok = ^pend_w;

endmodule

// File: tb/tb_smbus_ioexp_bank.sv
// Bench for smbus_ioexp_bank: directed interrupt sequences, register-map table, random vs model.
// Expectations follow IOEXP_POLARITY_EN when it is defined.
module tb_smbus_ioexp_bank;

   localparam int NP = 2;

`ifdef IOEXP_POLARITY_EN
   localparam bit POL_EN = 1'b1;
`else
   localparam bit POL_EN = 1'b0;
`endif

   logic          iClk, nrst, iWrEn, iRdEn, iIntEn_n, oIntN;
   logic [7:0]    iOffset, iWrData, oRdData;
   logic [8*NP-1:0] iPins, oPins;
   logic [NP-1:0] iCfgDflt;

   smbus_ioexp_bank #(.NPORTS(NP), .INT_HOLD_CYC(16)) dut (
      .iClk     (iClk),
      .nrst     (nrst),
      .iWrEn    (iWrEn),
      .iRdEn    (iRdEn),
      .iOffset  (iOffset),
      .iWrData  (iWrData),
      .oRdData  (oRdData),
      .iPins    (iPins),
      .iCfgDflt (iCfgDflt),
      .iIntEn_n (iIntEn_n),
      .oIntN    (oIntN),
      .oPins    (oPins)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] out_m [NP];
   logic [7:0] cfg_m [NP];
   logic [7:0] msk_m [NP];
   logic [7:0] pol_m [NP];

   typedef struct {
      logic [15:0] pins;
      logic        wr;
      logic [7:0]  woff;
      logic [7:0]  wdat;
      logic [7:0]  roff;
      logic [7:0]  exp;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic model_rst();
      for (int p = 0; p < NP; p++) begin
         out_m[p] = 8'hFF;
         pol_m[p] = 8'h00;
         msk_m[p] = 8'h00;
         cfg_m[p] = iCfgDflt[p] ? 8'hFF : 8'h00;
      end
   endtask

   task automatic model_wr(input logic [7:0] off, input logic [7:0] d);
      int base, idx;
      base = int'(off) / 16;
      idx  = int'(off) % 16;
      if (idx < NP) begin
         if (base == 1) out_m[idx] = d;
         if (base == 2 && POL_EN) pol_m[idx] = d;
         if (base == 3) cfg_m[idx] = d;
         if (base == 4) msk_m[idx] = d;
      end
   endtask

   function automatic logic [7:0] model_rd(input logic [7:0] off);
      int base, idx;
      logic [7:0] pin;
      base = int'(off) / 16;
      idx  = int'(off) % 16;
      if (idx >= NP || base > 4) return 8'hFF;
      pin = iPins[8*idx +: 8];
      case (base)
         0: return pin ^ pol_m[idx];
         1: return out_m[idx];
         2: return pol_m[idx];
         3: return cfg_m[idx];
         default: return msk_m[idx];
      endcase
   endfunction

   function automatic logic [15:0] model_drv();
      logic [15:0] r;
      for (int p = 0; p < NP; p++)
         for (int b = 0; b < 8; b++)
            r[8*p+b] = cfg_m[p][b] ? iPins[8*p+b] : out_m[p][b];
      return r;
   endfunction

   task automatic do_wr(input logic [7:0] off, input logic [7:0] d);
      iWrEn = 1'b1;
      iOffset = off;
      iWrData = d;
      tick();
      iWrEn = 1'b0;
      model_wr(off, d);
   endtask

   task automatic rd_strobe(input logic [7:0] off);
      iRdEn = 1'b1;
      iOffset = off;
      tick();
      iRdEn = 1'b0;
   endtask

   task automatic chk_rd(input string nm, input logic [7:0] off, input logic [7:0] exp);
      iOffset = off;
      #1;
      chk(nm, oRdData, exp);
   endtask

   task automatic wait_int(input string nm);
      int n = 0;
      do begin
         tick();
         n++;
      end while (oIntN !== 1'b0 && n < 2);
      chk(nm, oIntN, 0);
   endtask

   function automatic logic [7:0] rnd_off();
      if ($urandom_range(0, 5) == 5) return 8'($urandom);
      return {4'($urandom_range(0, 4)), 4'($urandom_range(0, 2))};
   endfunction

   initial begin
      logic [7:0] off, d;
      nrst = 1'b0;
      iWrEn = 1'b0;
      iRdEn = 1'b0;
      iOffset = 8'h00;
      iWrData = 8'h00;
      iPins = '0;
      iCfgDflt = 2'b01;
      iIntEn_n = 1'b0;
      model_rst();
      repeat (3) tick();
      chk("rst_intn_low", oIntN, 1);
      nrst = 1'b1;
      chk_rd("cfg0_rst", 8'h30, 8'hFF);
      chk_rd("cfg1_rst", 8'h31, 8'h00);
      chk_rd("out0_rst", 8'h10, 8'hFF);
      chk_rd("out1_rst", 8'h11, 8'hFF);
      chk_rd("msk0_rst", 8'h40, 8'h00);
      chk_rd("pol0_rst", 8'h20, 8'h00);
      chk("rst_intn", oIntN, 1);
      tick();
      tick();

      iPins = 16'h0808;
      wait_int("int_assert");
      iPins = 16'h0000;
      chk_rd("snap0", 8'h00, 8'h08);
      chk_rd("snap1", 8'h01, 8'h08);
      iRdEn = 1'b1;
      iOffset = 8'h00;
      iPins = 16'h0001;
      #1;
      chk("rd_same_cyc", oRdData, 8'h08);
      tick();
      iRdEn = 1'b0;
      chk("int_p1_pending", oIntN, 0);
      tick();
      tick();
      chk("int_p1_still", oIntN, 0);
      rd_strobe(8'h01);
      chk("int_clear", oIntN, 1);
      chk_rd("live_after_clr", 8'h00, 8'h01);

      for (int i = 1; i <= 17; i++) begin
         tick();
         if (i == 4) iPins = 16'h0003;
         chk("hold_quiet", oIntN, 1);
      end
      repeat (3) begin
         tick();
         chk("armed_quiet", oIntN, 1);
      end
      iPins = 16'h0007;
      wait_int("int_after_arm");
      chk_rd("snap_after_arm", 8'h00, 8'h07);
      rd_strobe(8'h00);
      chk("clr_after_arm", oIntN, 1);
      repeat (20) tick();

      do_wr(8'h40, 8'h08);
      iPins = 16'h000F;
      repeat (4) begin
         tick();
         chk("masked_quiet", oIntN, 1);
      end
      iPins = 16'h001F;
      wait_int("unmasked_int");
      rd_strobe(8'h00);
      chk("clr_unmasked", oIntN, 1);
      repeat (20) tick();

      do_wr(8'h10, 8'h00);
      chk_rd("out0_wr", 8'h10, 8'h00);
      iIntEn_n = 1'b1;
      iPins = 16'h003F;
      repeat (2) begin
         tick();
         chk("en_masked", oIntN, 1);
      end
      iIntEn_n = 1'b0;
      #1;
      chk("en_unmask", oIntN, 0);
      #2;
      nrst = 1'b0;
      #1;
      chk("rst_async", oIntN, 1);
      model_rst();
      tick();
      tick();
      nrst = 1'b1;
      chk_rd("out0_after_rst", 8'h10, 8'hFF);
      chk_rd("msk0_after_rst", 8'h40, 8'h00);
      chk_rd("cfg0_after_rst", 8'h30, 8'hFF);
      chk("intn_after_rst", oIntN, 1);
      tick();
      tick();

      vt[0]  = '{16'h003F, 1'b1, 8'h40, 8'hFF, 8'h40, 8'hFF};
      vt[1]  = '{16'h003F, 1'b1, 8'h41, 8'hFF, 8'h41, 8'hFF};
      vt[2]  = '{16'h000F, 1'b1, 8'h20, 8'hFF, 8'h00, POL_EN ? 8'hF0 : 8'h0F};
      vt[3]  = '{16'h000F, 1'b0, 8'h00, 8'h00, 8'h20, POL_EN ? 8'hFF : 8'h00};
      vt[4]  = '{16'h000F, 1'b1, 8'h00, 8'h55, 8'h00, POL_EN ? 8'hF0 : 8'h0F};
      vt[5]  = '{16'h000F, 1'b1, 8'h10, 8'h5A, 8'h10, 8'h5A};
      vt[6]  = '{16'h000F, 1'b1, 8'h31, 8'hF0, 8'h31, 8'hF0};
      vt[7]  = '{16'h000F, 1'b0, 8'h00, 8'h00, 8'h02, 8'hFF};
      vt[8]  = '{16'h000F, 1'b1, 8'h50, 8'h12, 8'h50, 8'hFF};
      vt[9]  = '{16'h000F, 1'b0, 8'h00, 8'h00, 8'h42, 8'hFF};
      vt[10] = '{16'h3C0F, 1'b1, 8'h21, 8'h0F, 8'h01, POL_EN ? 8'h33 : 8'h3C};
      vt[11] = '{16'h3C0F, 1'b1, 8'h20, 8'h00, 8'h00, 8'h0F};
      vt[12] = '{16'h3C0F, 1'b1, 8'h4F, 8'h00, 8'h4F, 8'hFF};
      for (int i = 0; i < 13; i++) begin
         iPins = vt[i].pins;
         if (vt[i].wr) do_wr(vt[i].woff, vt[i].wdat);
         chk_rd($sformatf("vec%0d", i), vt[i].roff, vt[i].exp);
      end
      chk("intn_after_table", oIntN, 1);

      for (int i = 0; i < 40; i++) begin
         iPins = 16'($urandom);
         off = rnd_off();
         d = 8'($urandom);
         if (off == 8'h40 || off == 8'h41) d = 8'hFF;
         if ($urandom_range(0, 1) == 1) do_wr(off, d);
         off = rnd_off();
         iOffset = off;
         #1;
         chk($sformatf("rnd_rd_%0h", off), oRdData, model_rd(off));
         chk("rnd_pins", oPins, model_drv());
         chk("rnd_intn", oIntN, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/smbus_ioexp_bank.md
SMBUS_IOEXP_BANK -- requirements
Module: smbus_ioexp_bank

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of 8-bit ports, legal 1..8.
REQ-002 SHALL have parameter INT_HOLD_CYC, default 2250, rearm hold-off in iClk cycles after interrupt clear, legal 1..65535.
REQ-003 SHALL have port iClk  input  1  clock.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iWrEn  input  1  one-cycle write strobe from the SMBus slave.
REQ-006 SHALL have port iRdEn  input  1  one-cycle read-complete strobe from the SMBus slave.
REQ-007 SHALL have port iOffset  input  8  register offset.
REQ-008 SHALL have port iWrData  input  8  write data.
REQ-009 SHALL have port oRdData  output  8  read data; combinational from iOffset.
REQ-010 SHALL have port iPins  input  8*NPORTS  synchronised pin levels; port p is bits [8p+7:8p].
REQ-011 SHALL have port iCfgDflt  input  NPORTS  per-port config reset select: 1 gives 0xFF (input), 0 gives 0x00 (output).
REQ-012 SHALL have port iIntEn_n  input  1  global interrupt enable, active-low.
REQ-013 SHALL have port oIntN  output  1  open-drain-style interrupt, active-low.
REQ-014 SHALL have port oPins  output  8*NPORTS  driven levels: config bit 1 passes the iPins bit, config bit 0 drives the output-register bit.

Function
REQ-015 SHALL decode, per port p, these offsets: INPUT 0x00+p (RO), OUTPUT 0x10+p, POLARITY 0x20+p, CONFIG 0x30+p, MASK 0x40+p; all other offsets SHALL read 0xFF and ignore writes.
REQ-016 SHALL read INPUT as the live iPins XOR POLARITY when oIntN=1, and as the latched snapshot XOR POLARITY when oIntN=0.
REQ-017 SHALL update writable registers on the iClk edge where iWrEn=1; a write to INPUT SHALL be ignored.
REQ-018 SHALL compare iPins with the snapshot on every cycle, restricted to bits with MASK=0; any difference while in ARMED SHALL load the snapshot from iPins and enter ASSERT the next cycle.
REQ-019 SHALL implement the FSM ARMING -> ARMED -> ASSERT -> HOLD -> ARMING.
- ARMING: 1 cycle; snapshot <= iPins; no interrupt.
- HOLD: counts INT_HOLD_CYC cycles, then goes to ARMING.
REQ-020 SHALL drive oIntN=0 only in ASSERT with iIntEn_n=0; iIntEn_n=1 only masks the output, and the FSM continues.
REQ-021 SHALL set pending bit p on ASSERT entry for every port with an unmasked change, and clear it on an iRdEn with iOffset=0x00+p.
REQ-022 SHALL leave ASSERT for HOLD on the cycle after the last pending bit clears, whatever order the ports are read in.
REQ-023 SHALL ignore pin changes during ASSERT and HOLD; a change still present at ARMING is taken into the snapshot silently, while a change after ARMING raises a new interrupt.
REQ-024 SHALL let a MASK write during ASSERT leave the pending bits unchanged.
REQ-025 SHALL, on an iRdEn in the same cycle as a pin change in ASSERT, return snapshot data and clear that port's pending bit.

Reset
REQ-026 SHALL, under nrst=0:
- set OUTPUT=0xFF, POLARITY=0x00 and MASK=0x00;
- set CONFIG per iCfgDflt;
- set snapshot=0, pending=0, hold counter=0;
- set the FSM to ARMING and oIntN=1.
REQ-027 SHALL make reset mid-ASSERT or mid-HOLD drop oIntN to 1 asynchronously, then restart at ARMING.

Configuration
REQ-028 SHALL, with macro IOEXP_POLARITY_EN defined, implement the POLARITY registers per REQ-015 and REQ-016.
REQ-029 SHALL, without IOEXP_POLARITY_EN, make POLARITY offsets read 0x00, ignore writes to them, apply no inversion, and infer no polarity flops.

Structure
REQ-030 SHALL place the offset base constants (0x00/0x10/0x20/0x30/0x40), the FSM state enum and the unmapped read value 0xFF in shared package ioexp_pkg.
REQ-031 SHALL instantiate NPORTS copies of sub-module ioexp_port_slice, each holding OUTPUT, CONFIG, MASK, POLARITY, snapshot, change detect and pending bit; the FSM and read mux stay in the top module.

Verification
REQ-032 SHALL cover: reset with iCfgDflt=2'b01 -> CONFIG0 reads 0xFF, CONFIG1 reads 0x00, OUTPUT reads 0xFF, oIntN=1.
REQ-033 SHALL cover: NPORTS=2 in ARMED, iPins[3] toggles -> oIntN=0 within 2 cycles; read 0x00 returns the snapshot; oIntN stays 0 until 0x01 is read, then oIntN=1 within 1 cycle.
REQ-034 SHALL cover: MASK0=0x08, toggle iPins[3] -> no interrupt; toggle iPins[4] -> interrupt.
REQ-035 SHALL cover: pin change during HOLD (INT_HOLD_CYC=16) -> no interrupt; a change 3 cycles after ARMING -> interrupt.
REQ-036 SHALL cover: with IOEXP_POLARITY_EN, write 0x20=0xFF, iPins[7:0]=0x0F -> read 0x00 returns 0xF0; without the macro the same sequence reads 0x0F and 0x20 reads 0x00.
REQ-037 SHALL cover: nrst asserted in ASSERT -> oIntN=1 immediately and OUTPUT=0xFF after release.
